// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: control inputs and fetch-state outputs shared between the sequencer and its controller.
interface fetch_sequencer_if #(
   parameter int PC_W        = 10,
   parameter int OFF_W       = 9,
   parameter int NUM_PROG    = 3,
   parameter int STACK_DEPTH = 4
);
   localparam int SEL_W = NUM_PROG > 1 ? $clog2(NUM_PROG) : 1;
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   logic             start;
   logic [SEL_W-1:0] prog_sel;
   logic             stall;
   logic             branch_en;
   logic             bSIGN;
   logic [OFF_W-1:0] bOFFSET;
   logic             jump_en;
   logic [PC_W-1:0]  jTARGET;
   logic             call_en;
   logic             ret_en;
   logic             halt;
   logic [PC_W-1:0]  PC;
   logic             running;
   logic             done;
   logic             fault;
   logic [SP_W-1:0]  sp;
   modport master (
      output start, prog_sel, stall, branch_en, bSIGN, bOFFSET, jump_en, jTARGET, call_en, ret_en, halt,
      input  PC, running, done, fault, sp
   );
   modport slave (
      input  start, prog_sel, stall, branch_en, bSIGN, bOFFSET, jump_en, jTARGET, call_en, ret_en, halt,
      output PC, running, done, fault, sp
   );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter with entry table, stall, branch/jump, call/return stack and IDLE/RUN/HALT/FAULT control.
module fetch_sequencer #(
   parameter int                          PC_W        = 10,
   parameter int                          OFF_W       = 9,
   parameter int                          NUM_PROG    = 3,
   parameter logic [NUM_PROG*PC_W-1:0]    PROG_BASE   = {10'd0, 10'd2, 10'd0},
   parameter int                          STACK_DEPTH = 4,
   parameter int                          HALT_PC     = 63
) (
   input logic              CLK,
   input logic              init_n,
   fetch_sequencer_if.slave bus
);
   localparam int SEL_W = NUM_PROG > 1 ? $clog2(NUM_PROG) : 1;
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
   typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_t;
   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [SP_W-1:0] sp_q, sp_d;
   logic            running_q, done_q, fault_q, push;
   logic [PC_W-1:0] stack_q [STACK_DEPTH];
   logic [PC_W-1:0] pc_inc, off, base;
   logic [SEL_W-1:0] sel;
   logic [IDX_W-1:0] pop_idx, push_idx;
   assign pc_inc   = pc_q + PC_W'(1);
   assign off      = PC_W'(bus.bOFFSET);
   // out-of-range program indices fall back to entry 0
   assign sel      = 32'(bus.prog_sel) < NUM_PROG ? bus.prog_sel : '0;
   assign base     = PROG_BASE[32'(sel)*PC_W +: PC_W];
   assign pop_idx  = IDX_W'(sp_q - SP_W'(1));
   assign push_idx = IDX_W'(sp_q);
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      sp_d    = sp_q;
      push    = 1'b0;
      case (state_q)
         IDLE, HALT: if (bus.start) begin
            state_d = RUN;
            pc_d    = base;
            sp_d    = '0;
         end
         RUN: if (!bus.stall) begin
            if (bus.halt || pc_q == PC_W'(HALT_PC)) state_d = HALT;
            else if (bus.ret_en) begin
               if (sp_q == '0) state_d = FAULT;
               else begin
                  pc_d = stack_q[pop_idx];
                  sp_d = sp_q - SP_W'(1);
               end
            end else if (bus.call_en) begin
               if (sp_q == SP_W'(STACK_DEPTH)) state_d = FAULT;
               else begin
                  push = 1'b1;
                  sp_d = sp_q + SP_W'(1);
                  pc_d = bus.jTARGET;
               end
            end else if (bus.jump_en) pc_d = bus.jTARGET;
            else if (bus.branch_en) pc_d = bus.bSIGN ? pc_q - off : pc_q + off;
            else pc_d = pc_inc;
         end
         default: ;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (!init_n) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         sp_q      <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         sp_q      <= sp_d;
         running_q <= state_d == RUN;
         done_q    <= state_d == HALT;
         fault_q   <= state_d == FAULT;
         if (push) stack_q[push_idx] <= pc_inc;
      end
   end
   assign bus.PC      = pc_q;
   assign bus.running = running_q;
   assign bus.done    = done_q;
   assign bus.fault   = fault_q;
   assign bus.sp      = sp_q;
endmodule
